// File: rtl/commit_unit.sv
// commit_unit: ROB-head retirement controller (RF write, LSQ handoff, mispredict flush); COMMIT_PERF_CNT_EN adds retire/flush counters
module commit_unit #(
    parameter int ROBSIZE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_commit_ready,
    input  logic [ROBSIZE-1:0] i_commit_rob_addr,
    input  logic [31:0]        i_commit_inst_pc,
    input  logic [31:0]        i_commit_value,
    input  logic [4:0]         i_commit_rd,
    input  logic               i_commit_exception,
    input  logic [1:0]         i_commit_load_store,
    input  logic               i_commit_rd_inst,
    input  logic [2:0]         i_commit_cont_tra_inst,
    output logic               o_commit,
    output logic               o_rf_we,
    output logic [4:0]         o_rf_rd,
    output logic [31:0]        o_rf_data,
    output logic [ROBSIZE-1:0] o_rf_rob_addr,
    output logic               o_store_req,
    input  logic               i_store_ack,
    output logic               o_load_req,
    input  logic               i_load_valid,
    input  logic [31:0]        i_load_data,
    output logic [ROBSIZE-1:0] o_lsq_rob_addr,
    output logic               o_flush,
    output logic [31:0]        o_redirect_pc,
    output logic               o_redirect_taken,
    output logic [31:0]        o_retired_count,
    output logic [31:0]        o_flush_count
);
    typedef enum logic [1:0] {IDLE, ST_WAIT, LD_WAIT, FLUSH} state_t;
    state_t      state;
    logic [4:0]  ld_rd;
    logic        ld_rd_inst;
    logic [31:0] redir_pc_q;
    logic        redir_taken_q;
    logic        idle_h;
    logic        mispredict;
    logic        alu_commit;
    logic        st_done;
    logic        ld_done;
    always_comb begin
        idle_h           = !rst && state == IDLE && i_commit_ready;
        mispredict       = i_commit_cont_tra_inst == 3'b001 && i_commit_exception;
        alu_commit       = idle_h && !mispredict && i_commit_load_store == 2'b00;
        st_done          = !rst && state == ST_WAIT && i_store_ack;
        ld_done          = !rst && state == LD_WAIT && i_load_valid;
        o_flush          = idle_h && mispredict;
        o_commit         = alu_commit || o_flush || st_done || ld_done;
        o_rf_we          = alu_commit ? (i_commit_rd_inst && i_commit_rd != 5'd0)
                                      : (ld_done && ld_rd_inst && ld_rd != 5'd0);
        o_rf_rd          = state == LD_WAIT ? ld_rd : i_commit_rd;
        o_rf_data        = state == LD_WAIT ? i_load_data : i_commit_value;
        o_rf_rob_addr    = state == LD_WAIT ? o_lsq_rob_addr : i_commit_rob_addr;
        o_redirect_pc    = o_flush ? i_commit_inst_pc : redir_pc_q;
        o_redirect_taken = o_flush ? i_commit_value[0] : redir_taken_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            o_store_req    <= 1'b0;
            o_load_req     <= 1'b0;
            o_lsq_rob_addr <= '0;
            ld_rd          <= '0;
            ld_rd_inst     <= 1'b0;
            redir_pc_q     <= '0;
            redir_taken_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_commit_ready) begin
                    if (mispredict) begin
                        state         <= FLUSH;
                        redir_pc_q    <= i_commit_inst_pc;
                        redir_taken_q <= i_commit_value[0];
                    end else if (i_commit_load_store[1]) begin
                        state          <= ST_WAIT;
                        o_store_req    <= 1'b1;
                        o_lsq_rob_addr <= i_commit_rob_addr;
                    end else if (i_commit_load_store[0]) begin
                        state          <= LD_WAIT;
                        o_load_req     <= 1'b1;
                        o_lsq_rob_addr <= i_commit_rob_addr;
                        ld_rd          <= i_commit_rd;
                        ld_rd_inst     <= i_commit_rd_inst;
                    end
                end
                ST_WAIT: if (i_store_ack) begin
                    state       <= IDLE;
                    o_store_req <= 1'b0;
                end
                LD_WAIT: if (i_load_valid) begin
                    state      <= IDLE;
                    o_load_req <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef COMMIT_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_retired_count <= '0;
            o_flush_count   <= '0;
        end else begin
            o_retired_count <= o_retired_count + 32'(o_commit);
            o_flush_count   <= o_flush_count + 32'(o_flush);
        end
    end
`else
    assign o_retired_count = '0;
    assign o_flush_count   = '0;
`endif
endmodule
